// File: rtl/cache_def.sv
// Shared types for the cache <-> main-memory interface.
// The main-memory responder and its line array import this package.
package cache_def;

    localparam int MEM_LINE_BITS = 128;

    typedef struct packed {
        logic [31:0]              addr;
        logic [MEM_LINE_BITS-1:0] data;
        logic                     rw;
        logic                     valid;
    } mem_req_type;

    typedef struct packed {
        logic [MEM_LINE_BITS-1:0] data;
        logic                     ready;
    } mem_data_type;

    typedef enum logic [1:0] {mem_idle, mem_wait, mem_resp} mem_state_type;

    // Power-up contents: every 32-bit word holds its own byte address.
    function automatic logic [MEM_LINE_BITS-1:0] init_line(input logic [27:0] line_addr);
        return {line_addr, 4'hC, line_addr, 4'h8, line_addr, 4'h4, line_addr, 4'h0};
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// Line storage for the main-memory model.
// It has one synchronous write port and one combinational read port, and it is preloaded with the address pattern.
module mem_line_array
    import cache_def::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [DEPTH_LOG2-1:0]    waddr_i,
    input  logic [MEM_LINE_BITS-1:0] wdata_i,
    input  logic [DEPTH_LOG2-1:0]    raddr_i,
    output logic [MEM_LINE_BITS-1:0] rdata_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [MEM_LINE_BITS-1:0] lines [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_line
        // Declaration initialiser gives the time-0 pattern; reset never touches it.
        logic [MEM_LINE_BITS-1:0] line_q = init_line(28'(g));

        always_ff @(posedge clk) begin
            if (we_i && (waddr_i == DEPTH_LOG2'(g))) begin
                line_q <= wdata_i;
            end
        end

        assign lines[g] = line_q;
    end

    assign rdata_o = lines[raddr_i];

endmodule

// File: rtl/cache_main_mem.sv
// This module is the main-memory responder below the cache.
// It accepts one line request, waits a fixed LATENCY, and then pulses ready for one cycle.
module cache_main_mem
    import cache_def::*;
#(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  mem_req_type  mem_req,
    output mem_data_type mem_data,
    output logic         busy
);

    mem_state_type            state_q;
    logic [7:0]               cnt_q;
    logic [31:4]              addr_q;
    logic [MEM_LINE_BITS-1:0] wdata_q;
    logic                     rw_q;
    logic [28:0]              last_tag_q;
    logic                     last_ok_q;
    logic                     prev_valid_q;
    logic                     ready_q;
    logic [MEM_LINE_BITS-1:0] rdata_q;
    logic                     busy_q;

    logic                     is_new;
    logic                     we;
    logic [DEPTH_LOG2-1:0]    raddr;
    logic [MEM_LINE_BITS-1:0] line_rd;
    logic                     unused_low_addr;

    assign unused_low_addr = ^mem_req.addr[3:0];

    // A request the requester simply left asserted after completion is not re-served.
    assign is_new = !prev_valid_q || !last_ok_q ||
                    ({mem_req.addr[31:4], mem_req.rw} != last_tag_q);

    // Reset in the RESP cycle must win over the commit.
    assign we    = (state_q == mem_resp) && rw_q && !rst;
    assign raddr = (state_q == mem_idle) ? mem_req.addr[4 +: DEPTH_LOG2] : addr_q[4 +: DEPTH_LOG2];

    mem_line_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_lines (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (addr_q[4 +: DEPTH_LOG2]),
        .wdata_i (wdata_q),
        .raddr_i (raddr),
        .rdata_o (line_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= mem_idle;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rw_q         <= 1'b0;
            last_tag_q   <= '0;
            last_ok_q    <= 1'b0;
            prev_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            prev_valid_q <= mem_req.valid;
            ready_q      <= 1'b0;
            case (state_q)
                mem_idle: begin
                    if (mem_req.valid && is_new) begin
                        addr_q  <= mem_req.addr[31:4];
                        wdata_q <= mem_req.data;
                        rw_q    <= mem_req.rw;
                        busy_q  <= 1'b1;
                        cnt_q   <= 8'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state_q <= mem_resp;
                            ready_q <= 1'b1;
                            if (!mem_req.rw) rdata_q <= line_rd;
                        end else begin
                            state_q <= mem_wait;
                        end
                    end
                end
                mem_wait: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_q <= mem_resp;
                        ready_q <= 1'b1;
                        if (!rw_q) rdata_q <= line_rd;
                    end
                end
                mem_resp: begin
                    state_q    <= mem_idle;
                    busy_q     <= 1'b0;
                    last_tag_q <= {addr_q, rw_q};
                    last_ok_q  <= 1'b1;
                end
                default: state_q <= mem_idle;
            endcase
        end
    end

    assign mem_data.ready = ready_q;
    assign mem_data.data  = rdata_q;
    assign busy           = busy_q;

endmodule
